gpu_cmd_dispatcher: RTL and testbench

CPU-side command initiator for the GPU16 command port. Accepts packed GPU commands from the CPU into a small FIFO and issues them one at a time over the gpu_start/busy handshake. Optionally captures the GPU result (gpu_data_reg) into a sticky result register. Sits between the CPU bus glue and GPU16 so the CPU never polls busy directly.

---
 rtl/gpu_cmd_dispatcher_pkg.sv | 27 ++
 rtl/gpu_cmd_dispatcher_fifo.sv | 57 +++++
 rtl/gpu_cmd_dispatcher.sv | 124 ++++++++++++
 tb/tb_gpu_cmd_dispatcher.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_cmd_dispatcher_pkg.sv
// Shared types for the GPU16 command dispatcher: packed command layout and FSM states.
package GPU_DispatchPackage;

  localparam int CMD_W = 88;

  // Bit layout matches the CPU-side packed command word (MSB first).
  typedef struct packed {
    logic        capture;      // [87]
    logic [4:0]  instruction;  // [86:82]
    logic [12:0] gpc_val_s;    // [81:69]
    logic [12:0] gpc_val_i;    // [68:56]
    logic [7:0]  inc_a;        // [55:48]
    logic [7:0]  inc_b;        // [47:40]
    logic [7:0]  repeat_amt;   // [39:32]
    logic [15:0] cpu_data;     // [31:16]
    logic [15:0] int_to_fp;    // [15:0]
  } gpu_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } dispatch_state_enum;

endpackage

// File: rtl/gpu_cmd_dispatcher_fifo.sv
// Synchronous command FIFO; DEPTH is a power of two so pointers wrap naturally.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 88
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Qualify requests against the registered state and advance pointers/occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_dispatcher.sv
// Queues CPU commands and issues them one at a time over the GPU16 start/busy handshake.
module gpu_cmd_dispatcher
  import GPU_DispatchPackage::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [87:0]            cmd,
  output logic                   gpu_start,
  output logic [4:0]             instruction,
  output logic [12:0]            gpc_val_s,
  output logic [12:0]            gpc_val_i,
  output logic [7:0]             gpc_inc_amount_a,
  output logic [7:0]             gpc_inc_amount_b,
  output logic [7:0]             repeat_op_amount,
  output logic [15:0]            cpu_data,
  output logic [15:0]            int_to_fp,
  input  logic                   gpu_busy,
  input  logic [15:0]            gpu_data,
  output logic                   res_valid,
  output logic [15:0]            res_data,
  input  logic                   res_ack,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] level
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  dispatch_state_enum state_q, state_d;
  gpu_cmd_t           issue_q, issue_d, head;
  logic [TW-1:0]      timer_q, timer_d;
  logic               res_valid_q, res_valid_d, gpu_start_q, gpu_start_d;
  logic [15:0]        res_data_q, res_data_d;
  logic               fifo_pop, fifo_full, fifo_empty;

  gpu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign cmd_ready        = !fifo_full;
  assign idle             = fifo_empty && (state_q == IDLE);
  assign gpu_start        = gpu_start_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign instruction      = issue_q.instruction;
  assign gpc_val_s        = issue_q.gpc_val_s;
  assign gpc_val_i        = issue_q.gpc_val_i;
  assign gpc_inc_amount_a = issue_q.inc_a;
  assign gpc_inc_amount_b = issue_q.inc_b;
  assign repeat_op_amount = issue_q.repeat_amt;
  assign cpu_data         = issue_q.cpu_data;
  assign int_to_fp        = issue_q.int_to_fp;

  // Dispatch FSM next-state, ack timer and result capture.
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    fifo_pop    = 1'b0;
    if (res_ack && res_valid_q) res_valid_d = 1'b0;
    case (state_q)
      // A capture command must not overwrite an unread result.
      IDLE: if (!fifo_empty && !(head.capture && res_valid_q)) begin
        fifo_pop = 1'b1;
        issue_d  = head;
        state_d  = ISSUE;
      end
      ISSUE: if (!gpu_busy) begin
        state_d = WAIT_BUSY;
        timer_d = '0;
      end
      // GPU may finish too quickly to ever show busy; give up after the timeout.
      WAIT_BUSY: begin
        if (gpu_busy)                              state_d = WAIT_DONE;
        else if (timer_q == TW'(ACK_TIMEOUT - 1))  state_d = COMPLETE;
        else                                       timer_d = timer_q + TW'(1);
      end
      WAIT_DONE: if (!gpu_busy) state_d = COMPLETE;
      // Capture takes priority over a same-cycle ack.
      COMPLETE: begin
        if (issue_q.capture) begin
          res_valid_d = 1'b1;
          res_data_d  = gpu_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gpu_start_d = (state_d == ISSUE);
  end

  // State, issue register, timer and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      gpu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      gpu_start_q <= gpu_start_d;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_dispatcher.sv
// Directed bench for gpu_cmd_dispatcher with a small GPU16 busy/data model and scoreboard queues.
module tb_gpu_cmd_dispatcher;
  import GPU_DispatchPackage::*;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, gpu_start, gpu_busy, res_valid, res_ack, idle;
  logic [87:0] cmd;
  logic [4:0]  instruction;
  logic [12:0] gpc_val_s, gpc_val_i;
  logic [7:0]  gpc_inc_amount_a, gpc_inc_amount_b, repeat_op_amount;
  logic [15:0] cpu_data, int_to_fp, gpu_data, res_data;
  logic [2:0]  level;
  logic [86:0] fields_o;

  int checks = 0, failures = 0, n_issued = 0;
  gpu_cmd_t    exp_q[$];
  logic [15:0] res_q[$];

  // GPU model controls
  logic hold_busy = 1'b0, no_ack = 1'b0, gm_busy;
  int   busy_len = 10, gm_cnt;
  logic [15:0] gm_res;

  always #5 clk = ~clk;

  gpu_cmd_dispatcher #(.DEPTH(4), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .gpu_start(gpu_start), .instruction(instruction), .gpc_val_s(gpc_val_s), .gpc_val_i(gpc_val_i),
    .gpc_inc_amount_a(gpc_inc_amount_a), .gpc_inc_amount_b(gpc_inc_amount_b),
    .repeat_op_amount(repeat_op_amount), .cpu_data(cpu_data), .int_to_fp(int_to_fp),
    .gpu_busy(gpu_busy), .gpu_data(gpu_data), .res_valid(res_valid), .res_data(res_data),
    .res_ack(res_ack), .idle(idle), .level(level)
  );

  assign fields_o = {instruction, gpc_val_s, gpc_val_i, gpc_inc_amount_a, gpc_inc_amount_b,
                     repeat_op_amount, cpu_data, int_to_fp};
  assign gpu_busy = gm_busy | hold_busy;

  // GPU16 stand-in: busy rises the cycle after acceptance for busy_len cycles, result = cpu_data.
  always @(posedge clk) begin
    if (reset) begin
      gm_busy  <= 1'b0;
      gm_cnt   <= 0;
      gm_res   <= '0;
      gpu_data <= '0;
    end else if (gm_busy) begin
      if (gm_cnt == 0) begin
        gm_busy  <= 1'b0;
        gpu_data <= gm_res;
      end else gm_cnt <= gm_cnt - 1;
    end else if (gpu_start && !gpu_busy && !no_ack) begin
      gm_busy <= 1'b1;
      gm_cnt  <= busy_len - 1;
      gm_res  <= cpu_data;
    end
  end

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare issued fields at acceptance and captured results on res_valid rise.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (gpu_start && !gpu_busy) begin
        n_issued++;
        if (exp_q.size() == 0) chk("issue_unexpected", 88'(fields_o), 88'h0);
        else begin
          gpu_cmd_t e;
          e = exp_q.pop_front();
          chk("issue_fields", 88'(fields_o), 88'(e[86:0]));
          if (e.capture) res_q.push_back(e.cpu_data);
        end
      end
      if (res_valid && !rv_prev) begin
        if (res_q.size() == 0) chk("res_unexpected", 88'(res_data), 88'h0);
        else chk("res_data", 88'(res_data), 88'(res_q.pop_front()));
      end
    end
    rv_prev = res_valid;
  end

  function automatic gpu_cmd_t mk(input logic cap, input logic [4:0] ins, input logic [7:0] rep,
                                  input logic [15:0] cd);
    gpu_cmd_t c;
    c.capture     = cap;
    c.instruction = ins;
    c.gpc_val_s   = cd[12:0] ^ 13'h0A5;
    c.gpc_val_i   = {ins, rep};
    c.inc_a       = rep + 8'd1;
    c.inc_b       = cd[15:8];
    c.repeat_amt  = rep;
    c.cpu_data    = cd;
    c.int_to_fp   = ~cd;
    return c;
  endfunction

  // Drive one command for one cycle; the scoreboard learns it only if cmd_ready allowed it.
  task automatic push(input gpu_cmd_t c, output logic acc);
    cmd_valid = 1'b1;
    cmd       = c;
    acc       = cmd_ready;
    if (acc) exp_q.push_back(c);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!idle && n < budget) begin @(negedge clk); n++; end
    chk(tag, 88'(idle), 88'd1);
  endtask

  initial begin
    logic acc;
    int   n, nstart;
    reset = 1'b1; cmd_valid = 1'b0; cmd = '0; res_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 88'(cmd_ready), 88'd1);
    chk("rst_gpu_start", 88'(gpu_start), 88'd0);
    chk("rst_fields", 88'(fields_o), 88'd0);
    chk("rst_res_valid", 88'(res_valid), 88'd0);
    chk("rst_res_data", 88'(res_data), 88'd0);
    chk("rst_idle", 88'(idle), 88'd1);
    chk("rst_level", 88'(level), 88'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single non-capture command: two-cycle latency, one-cycle gpu_start.
    busy_len = 10;
    push(mk(1'b0, 5'd3, 8'd2, 16'h1234), acc);
    cmd_valid = 1'b0;
    chk("t1_start_early", 88'(gpu_start), 88'd0);
    chk("t1_level", 88'(level), 88'd1);
    @(negedge clk);
    chk("t1_start_lat", 88'(gpu_start), 88'd1);
    nstart = 1; n = 0;
    while (!idle && n < 40) begin
      @(negedge clk); n++;
      if (gpu_start) nstart++;
    end
    chk("t1_start_cycles", 88'(nstart), 88'd1);
    chk("t1_idle", 88'(idle), 88'd1);
    chk("t1_res_valid", 88'(res_valid), 88'd0);
    chk("t1_instr_hold", 88'(instruction), 88'd3);
    chk("t1_repeat_hold", 88'(repeat_op_amount), 88'd2);

    // Capture command returning BEEF, then ack.
    push(mk(1'b1, 5'd7, 8'd1, 16'hBEEF), acc);
    cmd_valid = 1'b0;
    wait_idle("t2_idle", 40);
    chk("t2_res_valid", 88'(res_valid), 88'd1);
    chk("t2_res_data", 88'(res_data), 88'hBEEF);
    res_ack = 1'b1; @(negedge clk); res_ack = 1'b0;
    chk("t2_ack_clear", 88'(res_valid), 88'd0);

    // Fill the FIFO behind a command stuck in ISSUE.
    hold_busy = 1'b1; busy_len = 2;
    push(mk(1'b0, 5'd10, 8'd0, 16'h0100), acc);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_stuck_start", 88'(gpu_start), 88'd1);
    chk("t3_level0", 88'(level), 88'd0);
    for (int i = 1; i <= 4; i++) push(mk(1'b0, 5'(10 + i), 8'(i), 16'(16'h0100 + i)), acc);
    chk("t3_level_full", 88'(level), 88'd4);
    chk("t3_not_ready", 88'(cmd_ready), 88'd0);
    push(mk(1'b0, 5'd31, 8'd9, 16'hDEAD), acc);
    cmd_valid = 1'b0;
    chk("t3_fifth_refused", 88'(acc), 88'd0);
    chk("t3_level_still", 88'(level), 88'd4);
    n = n_issued;
    hold_busy = 1'b0;
    wait_idle("t3_idle", 200);
    chk("t3_issued", 88'(n_issued - n), 88'd5);
    chk("t3_sb_empty", 88'(exp_q.size()), 88'd0);

    // Second capture stalls until the first result is acked.
    busy_len = 3;
    push(mk(1'b1, 5'd4, 8'd3, 16'h1111), acc);
    push(mk(1'b1, 5'd5, 8'd4, 16'h2222), acc);
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("t4_stall_start", 88'(gpu_start), 88'd0);
    chk("t4_stall_level", 88'(level), 88'd1);
    chk("t4_stall_idle", 88'(idle), 88'd0);
    chk("t4_first_res", 88'(res_data), 88'h1111);
    res_ack = 1'b1; @(negedge clk); res_ack = 1'b0;
    chk("t4_ack_clear", 88'(res_valid), 88'd0);
    wait_idle("t4_idle", 40);
    chk("t4_second_valid", 88'(res_valid), 88'd1);
    chk("t4_second_res", 88'(res_data), 88'h2222);

    // Busy never rises: timeout completes, next issues (non-capture ignores pending result).
    no_ack = 1'b1;
    push(mk(1'b0, 5'd20, 8'd5, 16'h3333), acc);
    push(mk(1'b0, 5'd21, 8'd6, 16'h4444), acc);
    cmd_valid = 1'b0;
    n = 0;
    while (!gpu_start && n < 10) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!gpu_start && n < 20);
    chk("t5_timeout_gap", 88'(n), 88'd7);
    wait_idle("t5_idle", 40);
    chk("t5_res_kept", 88'(res_data), 88'h2222);
    no_ack = 1'b0;

    // Reset while in WAIT_DONE with three queued entries.
    busy_len = 20;
    push(mk(1'b0, 5'd1, 8'd1, 16'h5555), acc);
    cmd_valid = 1'b0;
    n = 0;
    while (!gpu_busy && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) push(mk(1'b0, 5'(2 + i), 8'(i), 16'(16'h6000 + i)), acc);
    cmd_valid = 1'b0;
    chk("t6_level3", 88'(level), 88'd3);
    chk("t6_busy", 88'(gpu_busy), 88'd1);
    chk("t6_res_pre", 88'(res_valid), 88'd1);
    reset = 1'b1; @(negedge clk);
    chk("t6_start", 88'(gpu_start), 88'd0);
    chk("t6_level", 88'(level), 88'd0);
    chk("t6_res_valid", 88'(res_valid), 88'd0);
    chk("t6_idle", 88'(idle), 88'd1);
    exp_q.delete();
    res_q.delete();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_post_idle", 88'(idle), 88'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
